adaptive_threshold: RTL and testbench
=====================================

# adaptive_threshold

Final stage of the adaptive-thresholding pipeline and the reader of the middle RAM that `box_filter` fills. Scans the frame row-major at one pixel per clock. For each pixel it reads the original intensity from the input ROM and the local mean from the middle RAM, then writes a binary pixel (0/255) to the result RAM. Runs while `global_state == 3'd2` and raises `finished` when the last pixel is written.

## Interface
Parameters:
- `WIDTH_BITS`, 8: column address width; frame width = 2^WIDTH_BITS.
- `HEIGHT_BITS`, 8: row address width; frame height = 2^HEIGHT_BITS.

Ports:
- `clock`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `global_state`  in  3: top-level phase; this block runs in phase 3'd2.
- `C`  in  5: threshold offset, unsigned 0..31.
- `oImageCol` / `oImageRow`  out  WIDTH_BITS / HEIGHT_BITS: input ROM read address.
- `iImageData`  in  8: ROM data, valid one cycle after its address.
- `oMiddleCol` / `oMiddleRow`  out  WIDTH_BITS / HEIGHT_BITS: middle RAM read address.
- `iMiddleData`  in  8: local mean, valid one cycle after its address.
- `oResultCol` / `oResultRow`  out  WIDTH_BITS / HEIGHT_BITS: result RAM write address.
- `oResultData`  out  8: binary pixel, 8'd0 or 8'd255.
- `oResultWren`  out  1: result write strobe.
- `finished`  out  1: frame complete.

## Operation
- FSM states:
  - IDLE: moves to RUN when `global_state == 3'd2`.
  - RUN: col/row counters advance once per cycle; col wraps to 0 and row increments; leaves RUN after issuing pixel (2^W−1, 2^H−1).
  - DRAIN: 2 cycles to empty the pipeline.
  - DONE: `finished = 1`; moves to IDLE the cycle after `global_state != 3'd2`.
- Both memories get the same address from the same counters.
- Decision: `white = ({1'b0,iImageData} + C) > {1'b0,iMiddleData}`, computed in 9-bit unsigned. This equals `image > mean − C`, with no underflow or overflow.
- `oResultData` = white ? 8'd255 : 8'd0.
- A 2-stage pipeline delays col/row (valid bit, col, row) to line up with the data.
- `oResultWren` is high only for valid pipeline entries, so every pixel is written exactly once per frame.
- Read addresses hold at (0,0) in IDLE, DRAIN and DONE.
- `C` and `global_state` are sampled every cycle. Changing `C` mid-frame affects later pixels only. This is not a supported use.
- Leaving `global_state == 3'd2` during RUN or DRAIN is ignored; the frame completes.

## Timing
- Reset values: every output is 0 and the FSM is in IDLE.
- Reset asserted mid-frame:
  - `oResultWren` and `finished` drop immediately (asynchronously).
  - The frame is aborted.
  - After release, if `global_state == 3'd2`, the scan restarts from (0,0).
- Cycle numbering: the first RUN cycle is t0, and pixel k's address is presented in cycle t0+k.
- Pixel k: data arrives in t0+k+1; the write (`oResultWren = 1`, registered outputs) happens in t0+k+2.
- Latency is 2 cycles; throughput is 1 pixel/cycle with no bubbles.
- With N = 2^(W+H), the last write is in t0+N+1, and `finished` rises in t0+N+2 and holds.
- A new frame requires `global_state` to leave 3'd2 and return.

## Configuration
- `ADAPTIVE_THRESHOLD_INVERT_EN`:
  - Defined: polarity is inverted; `oResultData` = white ? 8'd0 : 8'd255 (dark foreground on white background).
  - Undefined: polarity is as in Operation.
- Timing and all other behaviour are identical in both builds.

## Test plan
All scenarios use W=H=2 (N=16) with 1-cycle behavioural ROM/RAM models.
- Reset held with `global_state = 2` → all outputs 0; no writes.
- Image = 100 everywhere, mean = 100, C = 2, start at t0 → 16 writes of 255 in cycles t0+2..t0+17, row-major (0,0)..(3,3); `finished` rises at t0+18.
- Image = 50, mean = 60 → C=10 gives 0 (50+10 > 60 is false, equality boundary); C=11 gives 255.
- Image = 255, mean = 0, C = 31 gives 255; image = 0, mean = 255, C = 31 gives 0 (no wrap).
- Reset pulsed after the 7th write → `oResultWren` low immediately; after release with `global_state = 2`, exactly 16 writes starting again at (0,0).
- Hold `global_state = 2` after done → `finished` stays 1 with no further writes; set `global_state = 3` → `finished` 0 the next cycle. Repeat the frame with the macro defined → every output value inverted.

Source files
------------

// File: rtl/adaptive_threshold_if.sv
// Memory-side bus of adaptive_threshold: ROM/middle-RAM read ports and result-RAM write port.
// The master modport is the thresholding engine; the slave modport is the memory side.
interface adaptive_threshold_if #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8
);
    logic [WIDTH_BITS-1:0]  oImageCol;
    logic [HEIGHT_BITS-1:0] oImageRow;
    logic [7:0]             iImageData;
    logic [WIDTH_BITS-1:0]  oMiddleCol;
    logic [HEIGHT_BITS-1:0] oMiddleRow;
    logic [7:0]             iMiddleData;
    logic [WIDTH_BITS-1:0]  oResultCol;
    logic [HEIGHT_BITS-1:0] oResultRow;
    logic [7:0]             oResultData;
    logic                   oResultWren;

    modport master (
        output oImageCol, oImageRow, oMiddleCol, oMiddleRow,
        output oResultCol, oResultRow, oResultData, oResultWren,
        input  iImageData, iMiddleData
    );

    modport slave (
        input  oImageCol, oImageRow, oMiddleCol, oMiddleRow,
        input  oResultCol, oResultRow, oResultData, oResultWren,
        output iImageData, iMiddleData
    );
endinterface

// File: rtl/adaptive_threshold.sv
// Binary thresholding stage: image > local_mean - C, one pixel per clock, 2-cycle latency.
// Optional build macro ADAPTIVE_THRESHOLD_INVERT_EN swaps the output polarity (dark foreground).
module adaptive_threshold #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0]            global_state,
    input  logic [4:0]            C,
    adaptive_threshold_if.master  bus,
    output logic                  finished
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] PHASE_THRESHOLD = 3'd2;

    localparam logic [WIDTH_BITS-1:0]  COL_LAST = {WIDTH_BITS{1'b1}};
    localparam logic [HEIGHT_BITS-1:0] ROW_LAST = {HEIGHT_BITS{1'b1}};
    localparam logic [WIDTH_BITS-1:0]  COL_ZERO = {WIDTH_BITS{1'b0}};
    localparam logic [HEIGHT_BITS-1:0] ROW_ZERO = {HEIGHT_BITS{1'b0}};
    localparam logic [WIDTH_BITS-1:0]  COL_ONE  = {{(WIDTH_BITS-1){1'b0}}, 1'b1};
    localparam logic [HEIGHT_BITS-1:0] ROW_ONE  = {{(HEIGHT_BITS-1){1'b0}}, 1'b1};

    // 9-bit compare keeps image + C from wrapping and avoids computing mean - C.
    function automatic logic is_white(input logic [7:0] image, input logic [7:0] mean,
                                      input logic [4:0] offset);
        logic [8:0] lhs;
        lhs      = {1'b0, image} + {4'b0000, offset};
        is_white = (lhs > {1'b0, mean});
    endfunction

    function automatic logic [7:0] pixel_value(input logic white);
`ifdef ADAPTIVE_THRESHOLD_INVERT_EN
        pixel_value = white ? 8'd0 : 8'd255;
`else
        pixel_value = white ? 8'd255 : 8'd0;
`endif
    endfunction

    logic [1:0]             state_q,  state_d;
    logic [WIDTH_BITS-1:0]  col_q,    col_d;
    logic [HEIGHT_BITS-1:0] row_q,    row_d;
    logic                   drain_q,  drain_d;
    logic                   v1_q,     v1_d;
    logic [WIDTH_BITS-1:0]  col1_q,   col1_d;
    logic [HEIGHT_BITS-1:0] row1_q,   row1_d;
    logic                   wren_q,   wren_d;
    logic [WIDTH_BITS-1:0]  rcol_q,   rcol_d;
    logic [HEIGHT_BITS-1:0] rrow_q,   rrow_d;
    logic [7:0]             rdata_q,  rdata_d;
    logic                   fin_q,    fin_d;

    // Scan FSM and address counters; counters stay at (0,0) outside RUN.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                col_d   = COL_ZERO;
                row_d   = ROW_ZERO;
                drain_d = 1'b0;
                if (global_state == PHASE_THRESHOLD) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (col_q == COL_LAST) begin
                    col_d = COL_ZERO;
                    if (row_q == ROW_LAST) begin
                        row_d   = ROW_ZERO;
                        drain_d = 1'b0;
                        state_d = S_DRAIN;
                    end else begin
                        row_d = row_q + ROW_ONE;
                    end
                end else begin
                    col_d = col_q + COL_ONE;
                end
            end
            S_DRAIN: begin
                if (drain_q) begin
                    drain_d = 1'b0;
                    state_d = S_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            S_DONE: begin
                if (global_state != PHASE_THRESHOLD) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                col_d   = COL_ZERO;
                row_d   = ROW_ZERO;
                drain_d = 1'b0;
            end
        endcase
    end

    // Pipeline next-state: stage 1 tags the address in flight, stage 2 forms the write.
    always_comb begin
        v1_d   = (state_q == S_RUN);
        col1_d = col_q;
        row1_d = row_q;
        wren_d = v1_q;
        if (v1_q) begin
            rcol_d  = col1_q;
            rrow_d  = row1_q;
            rdata_d = pixel_value(is_white(bus.iImageData, bus.iMiddleData, C));
        end else begin
            rcol_d  = COL_ZERO;
            rrow_d  = ROW_ZERO;
            rdata_d = 8'd0;
        end
        fin_d = (state_d == S_DONE);
    end

    // Scan state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            col_q   <= COL_ZERO;
            row_q   <= ROW_ZERO;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            drain_q <= drain_d;
        end
    end

    // Pipeline and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1_q    <= 1'b0;
            col1_q  <= COL_ZERO;
            row1_q  <= ROW_ZERO;
            wren_q  <= 1'b0;
            rcol_q  <= COL_ZERO;
            rrow_q  <= ROW_ZERO;
            rdata_q <= 8'd0;
            fin_q   <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            col1_q  <= col1_d;
            row1_q  <= row1_d;
            wren_q  <= wren_d;
            rcol_q  <= rcol_d;
            rrow_q  <= rrow_d;
            rdata_q <= rdata_d;
            fin_q   <= fin_d;
        end
    end

    assign bus.oImageCol   = col_q;
    assign bus.oImageRow   = row_q;
    assign bus.oMiddleCol  = col_q;
    assign bus.oMiddleRow  = row_q;
    assign bus.oResultCol  = rcol_q;
    assign bus.oResultRow  = rrow_q;
    assign bus.oResultData = rdata_q;
    assign bus.oResultWren = wren_q;
    assign finished        = fin_q;

endmodule

// File: tb/tb_adaptive_threshold.sv
// Self-checking bench for adaptive_threshold on a 4x4 frame with 1-cycle ROM/RAM models.
module tb_adaptive_threshold;
    localparam int W = 2;
    localparam int H = 2;
    localparam int N = 16;

`ifdef ADAPTIVE_THRESHOLD_INVERT_EN
    localparam int PIX_WHITE = 0;
    localparam int PIX_BLACK = 255;
`else
    localparam int PIX_WHITE = 255;
    localparam int PIX_BLACK = 0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] gs    = 3'd0;
    logic [4:0] c_in  = 5'd0;
    logic       finished;

    adaptive_threshold_if #(.WIDTH_BITS(W), .HEIGHT_BITS(H)) bus ();

    adaptive_threshold #(.WIDTH_BITS(W), .HEIGHT_BITS(H)) dut (
        .clock        (clock),
        .reset        (reset),
        .global_state (gs),
        .C            (c_in),
        .bus          (bus),
        .finished     (finished)
    );

    always #5 clock = ~clock;

    logic [7:0] img_mem  [N];
    logic [7:0] mean_mem [N];

    // Memory models with one cycle of read latency.
    always @(posedge clock) begin
        bus.iImageData  <= img_mem[{bus.oImageRow, bus.oImageCol}];
        bus.iMiddleData <= mean_mem[{bus.oMiddleRow, bus.oMiddleCol}];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference rule: white when image + C exceeds the mean, computed in plain integers.
    function automatic int exp_pixel(input int k);
        int lhs;
        lhs = int'(img_mem[k]) + int'(c_in);
        return (lhs > int'(mean_mem[k])) ? PIX_WHITE : PIX_BLACK;
    endfunction

    // Model timeline: phase 0 idle, 1 frame active (t0 = first scan cycle), 2 done.
    int phase = 0;
    int cyc   = 0;
    int t0    = 0;
    int n_wr  = 0;
    int fin_rel = -1;
    logic [7:0] wr_data [N];
    logic [1:0] wr_col  [N];
    logic [1:0] wr_row  [N];

    initial begin
        int rel, k;
        bit exp_wren, addr_on;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                phase = 0;
            end else begin
                cyc++;
                if (phase == 2 && gs != 3'd2) phase = 0;
                else if (phase == 1 && cyc - t0 == N + 2) phase = 2;
                else if (phase == 0 && gs == 3'd2) begin
                    phase = 1;
                    t0    = cyc;
                end
            end
            #1;
            rel      = cyc - t0;
            exp_wren = (phase == 1) && rel >= 2 && rel <= N + 1;
            addr_on  = (phase == 1) && rel >= 0 && rel < N;
            chk("wren", bus.oResultWren, exp_wren);
            chk("finished", finished, phase == 2);
            chk("img_col", bus.oImageCol, addr_on ? rel % 4 : 0);
            chk("img_row", bus.oImageRow, addr_on ? rel / 4 : 0);
            chk("mid_col", bus.oMiddleCol, addr_on ? rel % 4 : 0);
            chk("mid_row", bus.oMiddleRow, addr_on ? rel / 4 : 0);
            if (exp_wren) begin
                k = rel - 2;
                chk("res_col", bus.oResultCol, k % 4);
                chk("res_row", bus.oResultRow, k / 4);
                chk("res_data", bus.oResultData, exp_pixel(k));
            end
            if (bus.oResultWren === 1'b1) begin
                if (n_wr < N) begin
                    wr_data[n_wr] = bus.oResultData;
                    wr_col[n_wr]  = bus.oResultCol;
                    wr_row[n_wr]  = bus.oResultRow;
                end
                n_wr++;
            end
            if (finished === 1'b1 && fin_rel < 0) fin_rel = rel;
        end
    end

    task automatic fill(input int img, input int mean);
        for (int i = 0; i < N; i++) begin
            img_mem[i]  = 8'(img);
            mean_mem[i] = 8'(mean);
        end
    endtask

    task automatic wait_finish(input string tag);
        int i;
        i = 0;
        while (finished !== 1'b1 && i < 60) begin
            @(negedge clock);
            i++;
        end
        chk({tag, "_finished"}, finished, 1);
        chk({tag, "_writes"}, n_wr, N);
        chk({tag, "_finish_cycle"}, fin_rel, 18);
    endtask

    task automatic start_frame();
        @(negedge clock);
        n_wr    = 0;
        fin_rel = -1;
        gs      = 3'd2;
    endtask

    task automatic end_frame();
        @(negedge clock);
        gs = 3'd0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        int i;
        fill(0, 0);
        reset = 1'b1;
        gs    = 3'd2;
        repeat (4) @(negedge clock);
        chk("rst_data", bus.oResultData, 0);
        chk("rst_wren", bus.oResultWren, 0);
        chk("rst_fin", finished, 0);
        chk("rst_writes", n_wr, 0);
        gs    = 3'd0;
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Uniform frame, then hold phase 2 after completion.
        fill(100, 100);
        c_in = 5'd2;
        start_frame();
        wait_finish("uniform");
        chk("uniform_first", wr_data[0], PIX_WHITE);
        chk("uniform_last", wr_data[15], PIX_WHITE);
        chk("uniform_first_addr", {wr_row[0], wr_col[0]}, 0);
        chk("uniform_last_addr", {wr_row[15], wr_col[15]}, 15);
        repeat (5) @(negedge clock);
        chk("hold_finished", finished, 1);
        chk("hold_writes", n_wr, N);
        gs = 3'd3;
        @(negedge clock);
        chk("leave_finished", finished, 0);
        end_frame();

        // Equality boundary: 50 + 10 is not greater than 60, 50 + 11 is.
        fill(50, 60);
        c_in = 5'd10;
        start_frame();
        wait_finish("eq10");
        chk("eq10_pixel", wr_data[0], PIX_BLACK);
        end_frame();
        c_in = 5'd11;
        start_frame();
        wait_finish("eq11");
        chk("eq11_pixel", wr_data[0], PIX_WHITE);
        end_frame();

        // Extremes: no overflow of 255 + 31, no underflow of 255 - 31.
        for (i = 0; i < N; i++) begin
            img_mem[i]  = (i % 2 == 0) ? 8'd255 : 8'd0;
            mean_mem[i] = (i % 2 == 0) ? 8'd0 : 8'd255;
        end
        c_in = 5'd31;
        start_frame();
        wait_finish("extreme");
        chk("extreme_hi", wr_data[0], PIX_WHITE);
        chk("extreme_lo", wr_data[1], PIX_BLACK);
        end_frame();

        // Random frames.
        for (int f = 0; f < 4; f++) begin
            for (int j = 0; j < N; j++) begin
                img_mem[j]  = 8'($urandom_range(0, 255));
                mean_mem[j] = 8'($urandom_range(0, 255));
            end
            c_in = 5'($urandom_range(0, 31));
            start_frame();
            wait_finish("random");
            end_frame();
        end

        // Reset pulsed mid-frame after the 7th write, then a full restart.
        start_frame();
        i = 0;
        while (n_wr < 7 && i < 40) begin
            @(negedge clock);
            i++;
        end
        chk("abort_seen_writes", n_wr, 7);
        chk("abort_wren_before", bus.oResultWren, 1);
        reset = 1'b1;
        #1;
        chk("abort_wren", bus.oResultWren, 0);
        chk("abort_fin", finished, 0);
        n_wr    = 0;
        fin_rel = -1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        wait_finish("restart");
        chk("restart_first_addr", {wr_row[0], wr_col[0]}, 0);
        chk("restart_last_addr", {wr_row[15], wr_col[15]}, 15);
        end_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
